// File: rtl/stepdown_loop_pulse_gen.sv
// Step-down converter loop pulse generator: qualifies a request, drives a
// dead-timed high-side/low-side pulse pair and latches a fault on runaway bursts.
module stepdown_loop_pulse_gen #(
    parameter int unsigned QUAL_N   = 3,
    parameter int unsigned TON_W    = 8,
    parameter int unsigned TOFF_MIN = 4,
    parameter int unsigned MAX_RUN  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             en,
    input  logic [TON_W-1:0] ton,
    input  logic             ilim,
    input  logic             fault_clr,
    output logic             hs_on,
    output logic             ls_on,
    output logic             busy,
    output logic             fault,
    output logic [3:0]       run_cnt,
    input  logic             CELV,
    input  logic             CELG,
    input  logic             CELSUB
);

    localparam int unsigned QW = $clog2(QUAL_N + 1);
    localparam int unsigned OW = $clog2(TOFF_MIN + 1);

    localparam logic [QW-1:0] QUAL_LAST = QW'(QUAL_N);
    localparam logic [OW-1:0] OFF_LOAD  = OW'(TOFF_MIN);
    localparam logic [3:0]    RUN_MAX   = 4'(MAX_RUN);
    localparam logic [3:0]    RUN_LAST  = 4'(MAX_RUN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUAL,
        S_DEAD_H,
        S_ON,
        S_DEAD_L,
        S_OFFMIN,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [QW-1:0]    qcnt_q, qcnt_d;
    logic [TON_W-1:0] tcnt_q, tcnt_d;
    logic [OW-1:0]    ocnt_q, ocnt_d;
    logic [3:0]       run_d;

    logic req_s1, req_s;
    logic ilim_s1, ilim_s;

    // Supply/ground/substrate pins carry no logic.
    logic unused_pwr;
    assign unused_pwr = ^{CELV, CELG, CELSUB};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_s1  <= 1'b0;
            req_s   <= 1'b0;
            ilim_s1 <= 1'b0;
            ilim_s  <= 1'b0;
        end else begin
            req_s1  <= req;
            req_s   <= req_s1;
            ilim_s1 <= ilim;
            ilim_s  <= ilim_s1;
        end
    end

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        tcnt_d  = tcnt_q;
        ocnt_d  = ocnt_q;
        run_d   = run_cnt;

        unique case (state_q)
            S_IDLE: begin
                if (en && req_s) begin
                    state_d = S_QUAL;
                    qcnt_d  = QW'(1);
                end
            end
            S_QUAL: begin
                if (qcnt_q == QUAL_LAST) begin
                    state_d = S_DEAD_H;
                end else if (req_s) begin
                    qcnt_d = qcnt_q + 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DEAD_H: begin
                state_d = S_ON;
                tcnt_d  = (ton == '0) ? TON_W'(1) : ton;
            end
            S_ON: begin
                if (ilim_s || (tcnt_q <= TON_W'(1))) begin
                    state_d = S_DEAD_L;
                end else begin
                    tcnt_d = tcnt_q - 1'b1;
                end
            end
            S_DEAD_L: begin
                state_d = S_OFFMIN;
                ocnt_d  = OFF_LOAD;
            end
            S_OFFMIN: begin
                if (ocnt_q <= OW'(1)) begin
                    if (!req_s) begin
                        state_d = S_IDLE;
                    end else if (run_cnt >= RUN_LAST) begin
                        state_d = S_FAULT;
                        run_d   = RUN_MAX;
                    end else begin
                        state_d = S_DEAD_H;
                        run_d   = run_cnt + 1'b1;
                    end
                end else begin
                    ocnt_d = ocnt_q - 1'b1;
                end
            end
            S_FAULT: begin
                if (fault_clr) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!en && (state_q != S_FAULT)) begin
            state_d = S_IDLE;
        end
        // Any return to IDLE ends the burst, so the run count restarts.
        if (state_d == S_IDLE) begin
            run_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            qcnt_q  <= '0;
            tcnt_q  <= '0;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            tcnt_q  <= tcnt_d;
            ocnt_q  <= ocnt_d;
        end
    end

    // Outputs are registered from the next state so they align with the
    // state register and never decode inputs combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_on   <= 1'b0;
            ls_on   <= 1'b0;
            busy    <= 1'b0;
            fault   <= 1'b0;
            run_cnt <= '0;
        end else begin
            hs_on   <= (state_d == S_ON);
            ls_on   <= (state_d == S_OFFMIN) ||
                       (((state_d == S_IDLE) || (state_d == S_QUAL)) && en);
            busy    <= !((state_d == S_IDLE) || (state_d == S_FAULT));
            fault   <= (state_d == S_FAULT);
            run_cnt <= run_d;
        end
    end

endmodule

// File: tb/tb_stepdown_loop_pulse_gen.sv
// Directed scoreboard bench for stepdown_loop_pulse_gen: expected per-cycle
// outputs are queued with the stimulus and popped one per clock.
module tb_stepdown_loop_pulse_gen;

    logic       clk;
    logic       rst;
    logic       req;
    logic       en;
    logic [7:0] ton;
    logic       ilim;
    logic       fault_clr;
    logic       hs_on;
    logic       ls_on;
    logic       busy;
    logic       fault;
    logic [3:0] run_cnt;
    logic       CELV;
    logic       CELG;
    logic       CELSUB;

    stepdown_loop_pulse_gen #(
        .QUAL_N   (3),
        .TON_W    (8),
        .TOFF_MIN (4),
        .MAX_RUN  (12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .en        (en),
        .ton       (ton),
        .ilim      (ilim),
        .fault_clr (fault_clr),
        .hs_on     (hs_on),
        .ls_on     (ls_on),
        .busy      (busy),
        .fault     (fault),
        .run_cnt   (run_cnt),
        .CELV      (CELV),
        .CELG      (CELG),
        .CELSUB    (CELSUB)
    );

    // {hs_on, ls_on, busy, fault}
    localparam logic [3:0] F_RST   = 4'b0000;
    localparam logic [3:0] F_IDLE  = 4'b0100;
    localparam logic [3:0] F_QUAL  = 4'b0110;
    localparam logic [3:0] F_DEAD  = 4'b0010;
    localparam logic [3:0] F_ON    = 4'b1010;
    localparam logic [3:0] F_OFF   = 4'b0110;
    localparam logic [3:0] F_FAULT = 4'b0001;

    typedef struct {
        string      tag;
        logic [7:0] v;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned vectors;
    int unsigned miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $error("FAIL timeout: sim time %0t reached, required finish before 100000", $time);
        $fatal(1, "bench did not finish");
    end

    task automatic push(input string tag, input int unsigned n,
                        input logic [3:0] flags, input logic [3:0] r);
        exp_t e;
        for (int unsigned i = 0; i < n; i++) begin
            e.tag = tag;
            e.v   = {flags, r};
            exp_q.push_back(e);
        end
    endtask

    task automatic check_now();
        exp_t       e;
        logic [7:0] obs;
        obs = {hs_on, ls_on, busy, fault, run_cnt};
        vectors++;
        assert (!(hs_on === 1'b1 && ls_on === 1'b1)) else begin
            miscompares++;
            $error("FAIL overlap: hs_on/ls_on=%b/%b required not both 1", hs_on, ls_on);
        end
        vectors++;
        assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL sb_empty: queue size %0d required nonzero", exp_q.size());
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            assert (obs === e.v) else begin
                miscompares++;
                $error("FAIL %s: hs/ls/busy/fault/run got %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                       e.tag, obs[7], obs[6], obs[5], obs[4], obs[3:0],
                       e.v[7], e.v[6], e.v[5], e.v[4], e.v[3:0]);
            end
        end
    endtask

    task automatic cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_now();
        end
    endtask

    // One qualified pulse with req dropped in time for OFFMIN to expire into IDLE.
    task automatic push_single(input string tag, input int unsigned on_n);
        push({tag, "_sync"}, 2, F_IDLE, 4'd0);
        push({tag, "_qual"}, 3, F_QUAL, 4'd0);
        push({tag, "_deadh"}, 1, F_DEAD, 4'd0);
        push({tag, "_on"}, on_n, F_ON, 4'd0);
        push({tag, "_deadl"}, 1, F_DEAD, 4'd0);
        push({tag, "_offmin"}, 4, F_OFF, 4'd0);
        push({tag, "_idle"}, 3, F_IDLE, 4'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1; en = 1'b0; req = 1'b0; ilim = 1'b0; fault_clr = 1'b0;
        ton = 8'd5; CELV = 1'b1; CELG = 1'b0; CELSUB = 1'b0;

        push("reset", 1, F_RST, 4'd0);
        cycles(1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        en  = 1'b1;
        #1;
        push("post_rst_hold", 1, F_RST, 4'd0);
        check_now();
        push("idle_en", 2, F_IDLE, 4'd0);
        cycles(2);

        // Basic pulse, ton=5
        ton = 8'd5; req = 1'b1;
        push_single("ton5", 5);
        cycles(14); req = 1'b0; cycles(5);

        // ton=0 behaves as a single on-cycle
        ton = 8'd0; req = 1'b1;
        push_single("ton0", 1);
        cycles(10); req = 1'b0; cycles(5);

        // Two-cycle request never qualifies
        ton = 8'd5; req = 1'b1;
        push("short_sync", 2, F_IDLE, 4'd0);
        push("short_qual", 2, F_QUAL, 4'd0);
        push("short_idle", 3, F_IDLE, 4'd0);
        cycles(2); req = 1'b0; cycles(5);

        // Current limit cuts a ton=10 pulse after 5 on-cycles
        ton = 8'd10; req = 1'b1;
        push_single("ilim", 5);
        cycles(9); ilim = 1'b1; cycles(1); ilim = 1'b0; cycles(4); req = 1'b0; cycles(5);

        // Enable dropped in OFFMIN
        ton = 8'd5; req = 1'b1;
        push("endrop_sync", 2, F_IDLE, 4'd0);
        push("endrop_qual", 3, F_QUAL, 4'd0);
        push("endrop_deadh", 1, F_DEAD, 4'd0);
        push("endrop_on", 5, F_ON, 4'd0);
        push("endrop_deadl", 1, F_DEAD, 4'd0);
        push("endrop_offmin", 2, F_OFF, 4'd0);
        cycles(14);
        en = 1'b0; req = 1'b0;
        push("endrop_off", 3, F_RST, 4'd0);
        cycles(3);
        en = 1'b1;
        push("endrop_reen", 2, F_IDLE, 4'd0);
        cycles(2);

        // Twelve back-to-back pulses latch the fault
        ton = 8'd5; req = 1'b1;
        push("run_sync", 2, F_IDLE, 4'd0);
        push("run_qual", 3, F_QUAL, 4'd0);
        for (int unsigned k = 0; k < 12; k++) begin
            push("run_deadh", 1, F_DEAD, 4'(k));
            push("run_on", 5, F_ON, 4'(k));
            push("run_deadl", 1, F_DEAD, 4'(k));
            push("run_offmin", 4, F_OFF, 4'(k));
        end
        push("run_fault", 4, F_FAULT, 4'd12);
        cycles(138);
        req = 1'b0; en = 1'b0;
        cycles(3);
        en = 1'b1; fault_clr = 1'b1;
        push("fault_clr", 1, F_IDLE, 4'd0);
        cycles(1);
        fault_clr = 1'b0;
        push("post_clr", 2, F_IDLE, 4'd0);
        cycles(2);

        // Reset asserted mid-pulse
        ton = 8'd5; req = 1'b1;
        push("rston_sync", 2, F_IDLE, 4'd0);
        push("rston_qual", 3, F_QUAL, 4'd0);
        push("rston_deadh", 1, F_DEAD, 4'd0);
        push("rston_on", 2, F_ON, 4'd0);
        cycles(8);
        #3;
        rst = 1'b1;
        #1;
        push("rston_async", 1, F_RST, 4'd0);
        check_now();
        req = 1'b0;
        push("rston_held", 1, F_RST, 4'd0);
        cycles(1);
        #2;
        rst = 1'b0;
        #1;
        push("rston_release", 1, F_RST, 4'd0);
        check_now();
        push("rston_idle", 2, F_IDLE, 4'd0);
        cycles(2);

        vectors++;
        assert (exp_q.size() == 0) else begin
            miscompares++;
            $error("FAIL sb_leftover: %0d entries left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stepdown_loop_pulse_gen.md
STEPDOWN_LOOP_PULSE_GEN -- requirements
Module: stepdown_loop_pulse_gen

Interface
REQ-001 The block SHALL provide parameter QUAL_N, default 3: consecutive synchronized req-high cycles needed to start a pulse.
REQ-002 The block SHALL provide parameter TON_W, default 8: width of the on-time bus.
REQ-003 The block SHALL provide parameter TOFF_MIN, default 4: low-side minimum-off cycles after every pulse.
REQ-004 The block SHALL provide parameter MAX_RUN, default 12: back-to-back pulses that latch a fault.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 The block SHALL have port clk, input, width 1: the clock.
REQ-007 The block SHALL have port rst, input, width 1: asynchronous active-high reset.
REQ-008 The block SHALL have port req, input, width 1: qualified loop request from the upstream input stage, asynchronous to clk.
REQ-009 The block SHALL have port en, input, width 1: loop enable.
REQ-010 The block SHALL have port ton, input, width TON_W: on-time in clk cycles.
REQ-011 The block SHALL have port ilim, input, width 1: current-limit trip, asynchronous to clk.
REQ-012 The block SHALL have port fault_clr, input, width 1: clears the latched fault.
REQ-013 The block SHALL have port hs_on, output, width 1: high-side drive.
REQ-014 The block SHALL have port ls_on, output, width 1: low-side drive.
REQ-015 The block SHALL have port busy, output, width 1: high in every state except IDLE and FAULT.
REQ-016 The block SHALL have port fault, output, width 1: latched run fault.
REQ-017 The block SHALL have port run_cnt, output, width 4: current consecutive-pulse count.
REQ-018 The block SHALL have ports CELV, CELG and CELSUB, input, width 1 each: supply, ground and substrate, with no logical function.

Function
REQ-019 req and ilim SHALL each pass through a 2-flop synchronizer (req_s, ilim_s); all decisions below use the synchronized versions.
REQ-020 The FSM SHALL have the states IDLE, QUAL, DEAD_H, ON, DEAD_L, OFFMIN and FAULT.
REQ-021 IDLE SHALL drive hs_on=0 and ls_on=en, and SHALL go to QUAL with qual count=1 when en=1 and req_s=1.
REQ-022 QUAL SHALL increment the qual count while req_s=1, SHALL return to IDLE when req_s=0, and SHALL go to DEAD_H when the count reaches QUAL_N.
REQ-023 DEAD_H SHALL last exactly 1 cycle with hs_on=0 and ls_on=0, and SHALL latch ton (ton=0 treated as 1).
REQ-024 ON SHALL drive hs_on=1 and ls_on=0 for the latched ton cycles, then go to DEAD_L.
REQ-025 An ilim_s=1 seen in ON SHALL end the pulse, and hs_on SHALL fall on the next edge.
REQ-026 DEAD_L SHALL last exactly 1 cycle with both outputs low, then go to OFFMIN.
REQ-027 OFFMIN SHALL drive ls_on=1 for exactly TOFF_MIN cycles, even when req_s stays high.
REQ-028 When OFFMIN expires with req_s=1, the FSM SHALL go to DEAD_H directly (no re-qualification) and run_cnt SHALL increment.
REQ-029 When OFFMIN expires with req_s=0, the FSM SHALL go to IDLE and run_cnt SHALL clear to 0.
REQ-030 When run_cnt reaches MAX_RUN, the FSM SHALL go to FAULT instead of DEAD_H.
REQ-031 FAULT SHALL drive hs_on=0, ls_on=0 and fault=1, and SHALL go to IDLE with run_cnt=0 on fault_clr=1.
REQ-032 en=0 in any non-FAULT state SHALL force IDLE on the next edge; hs_on and ls_on SHALL both be 0 while en=0.
REQ-033 run_cnt SHALL never wrap and SHALL stop at MAX_RUN.
REQ-034 hs_on and ls_on SHALL never both be 1 in any cycle, including across reset.
REQ-035 All outputs SHALL be driven directly from flops, with no combinational path from inputs.

Reset
REQ-036 rst=1 SHALL immediately force IDLE, hs_on=0, ls_on=0, busy=0, fault=0, run_cnt=0, and clear the synchronizers and counters.
REQ-037 Reset asserted mid-pulse SHALL drop hs_on asynchronously, without waiting for a clock edge.
REQ-038 After rst deasserts, the outputs SHALL hold their reset values until the first clock edge.

Verification
REQ-039 Scenario: en=1, req=1 held, ton=5 -> hs_on rises 2 (sync) + 3 (qual) + 1 (dead) cycles after req; it is high 5 cycles; 1 dead cycle follows; ls_on is high 4 cycles.
REQ-040 Scenario: req pulse of 2 cycles -> no hs_on, and the FSM returns to IDLE.
REQ-041 Scenario: ton=10, ilim pulsed at pulse cycle 3 -> hs_on falls 3 cycles later (2 sync + 1), followed by the normal dead and OFFMIN sequence.
REQ-042 Scenario: req held for 12 pulses -> fault=1 with both outputs 0; fault_clr=1 -> IDLE, run_cnt=0.
REQ-043 Scenario: rst asserted during ON -> hs_on=0 immediately and all outputs at reset values.
REQ-044 Scenario: en dropped during OFFMIN -> ls_on=0 on the next edge, state IDLE; throughout every run, hs_on and ls_on are never both 1.
